// File: rtl/bram_pipelined.sv
// Simple-dual-port block RAM with byte-masked writes, configurable read latency,
// selectable read-during-write policy and a zero-fill sequence after reset.
module bram_pipelined #(
  parameter int BRAM_ID     = 0,
  parameter int DATA_W      = 64,
  parameter int ADDR_W      = 10,
  parameter int RD_LAT      = 1,
  parameter bit WRITE_FIRST = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_busy,
  input  logic                  ren,
  input  logic [ADDR_W-1:0]     raddr,
  output logic                  rvalid,
  output logic [DATA_W-1:0]     rdata,
  input  logic                  wen,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wmask
);

  localparam int NBYTES = DATA_W / 8;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic {INIT, READY} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   clr_cnt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                wr_acc;
  logic                rd_acc;
  logic [DATA_W-1:0]   old_word;
  logic [DATA_W-1:0]   wr_word;
  logic [DATA_W-1:0]   rd_word;
  logic                pipe_valid [RD_LAT];
  logic [DATA_W-1:0]   pipe_data  [RD_LAT];

  // The instance identifier is platform bookkeeping only and drives no logic.
  logic [31:0] unused_id;
  assign unused_id = BRAM_ID;

  assign wr_acc = wen && (state == READY);
  assign rd_acc = ren && (state == READY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT;
      clr_cnt   <= '0;
      init_busy <= 1'b1;
    end else if (state == INIT) begin
      clr_cnt <= clr_cnt + ADDR_W'(1);
      if (clr_cnt == LAST_ADDR) begin
        state     <= READY;
        init_busy <= 1'b0;
      end
    end
  end

  always_comb begin
    old_word = mem[waddr];
    wr_word  = old_word;
    for (int b = 0; b < NBYTES; b++) begin
      if (wmask[b]) begin
        wr_word[8*b +: 8] = wdata[8*b +: 8];
      end
    end
  end

  // A same-address write forwards its merged word only under the write-first policy.
  always_comb begin
    rd_word = mem[raddr];
    if (WRITE_FIRST && wr_acc && (waddr == raddr)) begin
      rd_word = wr_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) begin
        mem[clr_cnt] <= '0;
      end else if (wen) begin
        mem[waddr] <= wr_word;
      end
    end
  end

  // Data stages only load behind a valid stage, so the last one holds the last result.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < RD_LAT; s++) begin
        pipe_valid[s] <= 1'b0;
        pipe_data[s]  <= '0;
      end
    end else begin
      pipe_valid[0] <= rd_acc;
      if (rd_acc) begin
        pipe_data[0] <= rd_word;
      end
      for (int s = 1; s < RD_LAT; s++) begin
        pipe_valid[s] <= pipe_valid[s-1];
        if (pipe_valid[s-1]) begin
          pipe_data[s] <= pipe_data[s-1];
        end
      end
    end
  end

  assign rvalid = pipe_valid[RD_LAT-1];
  assign rdata  = pipe_data[RD_LAT-1];

endmodule

// File: tb/tb_bram_pipelined.sv
// Directed bench for bram_pipelined: four instances sharing one stimulus stream,
// covering read latencies 1/2/4 and both read-during-write policies.
module tb_bram_pipelined;

  localparam int DW   = 64;
  localparam int AW   = 4;
  localparam int NDUT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          ren;
  logic          wen;
  logic [AW-1:0] raddr;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [7:0]    wmask;

  logic          ib [NDUT];
  logic          rv [NDUT];
  logic [DW-1:0] rd [NDUT];

  int checks = 0;
  int passes = 0;

  logic [DW-1:0] holdData [NDUT];
  logic [DW-1:0] expData  [NDUT][16];
  logic [AW-1:0] rdAddr [16];
  logic          wrEn   [16];
  logic [AW-1:0] wrAddr [16];
  logic [DW-1:0] wrData [16];
  logic [7:0]    wrMask [16];

  always #5 clk = ~clk;

  bram_pipelined #(.BRAM_ID(0), .DATA_W(DW), .ADDR_W(AW), .RD_LAT(2), .WRITE_FIRST(1'b0)) u_lat2_wf0 (
    .clk(clk), .rst(rst), .init_busy(ib[0]), .ren(ren), .raddr(raddr), .rvalid(rv[0]), .rdata(rd[0]),
    .wen(wen), .waddr(waddr), .wdata(wdata), .wmask(wmask));
  bram_pipelined #(.BRAM_ID(1), .DATA_W(DW), .ADDR_W(AW), .RD_LAT(2), .WRITE_FIRST(1'b1)) u_lat2_wf1 (
    .clk(clk), .rst(rst), .init_busy(ib[1]), .ren(ren), .raddr(raddr), .rvalid(rv[1]), .rdata(rd[1]),
    .wen(wen), .waddr(waddr), .wdata(wdata), .wmask(wmask));
  bram_pipelined #(.BRAM_ID(2), .DATA_W(DW), .ADDR_W(AW), .RD_LAT(1), .WRITE_FIRST(1'b0)) u_lat1_wf0 (
    .clk(clk), .rst(rst), .init_busy(ib[2]), .ren(ren), .raddr(raddr), .rvalid(rv[2]), .rdata(rd[2]),
    .wen(wen), .waddr(waddr), .wdata(wdata), .wmask(wmask));
  bram_pipelined #(.BRAM_ID(3), .DATA_W(DW), .ADDR_W(AW), .RD_LAT(4), .WRITE_FIRST(1'b0)) u_lat4_wf0 (
    .clk(clk), .rst(rst), .init_busy(ib[3]), .ren(ren), .raddr(raddr), .rvalid(rv[3]), .rdata(rd[3]),
    .wen(wen), .waddr(waddr), .wdata(wdata), .wmask(wmask));

  function automatic int latOf(input int i);
    case (i)
      0, 1:    return 2;
      2:       return 1;
      default: return 4;
    endcase
  endfunction

  function automatic bit wfOf(input int i);
    return (i == 1);
  endfunction

  task automatic checkOutput(input string tag, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%h, expected 0x%h", tag, actual, expected);
  endtask

  // Drives one edge worth of inputs, then returns 1 time unit after that edge.
  task automatic applyStimulus(input logic r, input logic [AW-1:0] ra, input logic w,
                               input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic [7:0] wm);
    ren   = r;
    raddr = ra;
    wen   = w;
    waddr = wa;
    wdata = wd;
    wmask = wm;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, 1'b0, '0, '0, '0);
  endtask

  task automatic setVec(input int c, input logic [AW-1:0] ra, input logic w,
                        input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic [7:0] wm);
    rdAddr[c] = ra;
    wrEn[c]   = w;
    wrAddr[c] = wa;
    wrData[c] = wd;
    wrMask[c] = wm;
  endtask

  task automatic setExpAll(input int c, input logic [DW-1:0] v);
    for (int i = 0; i < NDUT; i++) expData[i][c] = v;
  endtask

  // Reads issued on n consecutive edges; instance i must deliver read k after edge k+lat-1.
  task automatic streamRead(input string tag, input int n);
    for (int c = 0; c < n + 4; c++) begin
      if (c < n) applyStimulus(1'b1, rdAddr[c], wrEn[c], wrAddr[c], wrData[c], wrMask[c]);
      else idle();
      for (int i = 0; i < NDUT; i++) begin
        int   k;
        logic expV;
        k    = c - latOf(i) + 1;
        expV = (k >= 0) && (k < n);
        if (expV) holdData[i] = expData[i][k];
        checkOutput($sformatf("%s d%0d rvalid c%0d", tag, i, c), DW'(rv[i]), DW'(expV));
        checkOutput($sformatf("%s d%0d rdata c%0d", tag, i, c), rd[i], holdData[i]);
      end
    end
  endtask

  task automatic runClear(input string tag, input int accessEdge);
    for (int k = 1; k <= 16; k++) begin
      if (k == accessEdge) applyStimulus(1'b1, AW'(2), 1'b1, AW'(2), '1, 8'hFF);
      else idle();
      for (int i = 0; i < NDUT; i++) begin
        checkOutput($sformatf("%s d%0d init_busy e%0d", tag, i, k), DW'(ib[i]), DW'(k < 16));
        checkOutput($sformatf("%s d%0d rvalid e%0d", tag, i, k), DW'(rv[i]), '0);
        checkOutput($sformatf("%s d%0d rdata e%0d", tag, i, k), rd[i], '0);
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    ren   = 1'b0;
    wen   = 1'b0;
    raddr = '0;
    waddr = '0;
    wdata = '0;
    wmask = '0;
    for (int i = 0; i < NDUT; i++) holdData[i] = '0;

    repeat (3) idle();
    for (int i = 0; i < NDUT; i++) begin
      checkOutput($sformatf("reset d%0d init_busy", i), DW'(ib[i]), DW'(1'b1));
      checkOutput($sformatf("reset d%0d rvalid", i), DW'(rv[i]), '0);
      checkOutput($sformatf("reset d%0d rdata", i), rd[i], '0);
    end

    // Clear with a write+read of addr 2 attempted at edge 4, which must be ignored.
    rst = 1'b0;
    runClear("clear", 4);

    for (int c = 0; c < 16; c++) begin
      setVec(c, AW'(c), 1'b0, '0, '0, '0);
      setExpAll(c, '0);
    end
    streamRead("zeros", 16);

    applyStimulus(1'b0, '0, 1'b1, AW'(5), 64'h1122334455667788, 8'hFF);
    applyStimulus(1'b0, '0, 1'b1, AW'(5), 64'hAAAAAAAAAAAAAAAA, 8'h0F);
    setVec(0, AW'(5), 1'b0, '0, '0, '0);
    setExpAll(0, 64'h11223344AAAAAAAA);
    streamRead("mask", 1);

    // Same-address collisions: full-mask then a single-byte merge.
    applyStimulus(1'b0, '0, 1'b1, AW'(3), 64'h1, 8'hFF);
    setVec(0, AW'(3), 1'b1, AW'(3), 64'h2, 8'hFF);
    setVec(1, AW'(3), 1'b0, '0, '0, '0);
    setVec(2, AW'(3), 1'b1, AW'(3), '1, 8'h01);
    setVec(3, AW'(3), 1'b0, '0, '0, '0);
    for (int i = 0; i < NDUT; i++) begin
      expData[i][0] = wfOf(i) ? 64'h2 : 64'h1;
      expData[i][1] = 64'h2;
      expData[i][2] = wfOf(i) ? 64'hFF : 64'h2;
      expData[i][3] = 64'hFF;
    end
    streamRead("collide", 4);

    // Streaming; the write to addr 0 one edge after its read must not reach the in-flight data.
    for (int k = 0; k < 16; k++) applyStimulus(1'b0, '0, 1'b1, AW'(k), DW'(k), 8'hFF);
    for (int c = 0; c < 16; c++) begin
      setVec(c, AW'(c), 1'b0, '0, '0, '0);
      setExpAll(c, DW'(c));
    end
    setVec(1, AW'(1), 1'b1, AW'(0), 64'hDEAD, 8'hFF);
    streamRead("stream", 16);

    // Reset one edge after a read of addr 7: only the latency-1 instance completes it.
    applyStimulus(1'b1, AW'(7), 1'b0, '0, '0, '0);
    for (int i = 0; i < NDUT; i++) begin
      if (latOf(i) == 1) holdData[i] = 64'h7;
      checkOutput($sformatf("midrd d%0d rvalid", i), DW'(rv[i]), DW'(latOf(i) == 1));
      checkOutput($sformatf("midrd d%0d rdata", i), rd[i], holdData[i]);
    end
    rst = 1'b1;
    idle();
    for (int i = 0; i < NDUT; i++) begin
      holdData[i] = '0;
      checkOutput($sformatf("midrst d%0d init_busy", i), DW'(ib[i]), DW'(1'b1));
      checkOutput($sformatf("midrst d%0d rvalid", i), DW'(rv[i]), '0);
      checkOutput($sformatf("midrst d%0d rdata", i), rd[i], '0);
    end
    rst = 1'b0;
    runClear("reclear", 0);
    setVec(0, AW'(7), 1'b0, '0, '0, '0);
    setExpAll(0, '0);
    streamRead("after reset", 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/bram_pipelined.md
# bram_pipelined

Parametrised, synthesizable simple-dual-port block RAM model: one write port, one read port, one clock. It is the next generation of the team's single-cycle DPI-backed test-platform BRAM, adding configurable data width, depth and read latency, a selectable read-during-write policy, a read-valid output, and a hardware memory-clear sequence after reset. It sits between the test platform's DMA/stimulus logic and the multiplication datapath as a drop-in operand/result store.

## Interface
Parameters:
- BRAM_ID, 0, instance identifier; carried for platform bookkeeping, no functional effect.
- DATA_W, 64, word width in bits; must be a multiple of 8, range 8..512.
- ADDR_W, 10, word-address width; DEPTH = 2^ADDR_W words.
- RD_LAT, 1, read latency in cycles; legal values 1..4.
- WRITE_FIRST, 0, same-address read-during-write policy: 0 returns old data, 1 returns new merged data.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- init_busy  out  1  high during reset and memory clear; accesses ignored while high.
- ren  in  1  read request.
- raddr  in  ADDR_W  read word address.
- rvalid  out  1  rdata holds the result of a read issued RD_LAT cycles earlier.
- rdata  out  DATA_W  read data.
- wen  in  1  write request.
- waddr  in  ADDR_W  write word address.
- wdata  in  DATA_W  write data.
- wmask  in  DATA_W/8  byte enables; bit i covers wdata[8i+7:8i].

## Operation
- FSM states: INIT, READY. Any edge with rst high: state INIT, clear counter 0, read pipeline flushed (all valid stages 0), rdata 0, rvalid 0, init_busy 1.
- INIT with rst low: each edge writes all-zero to word[counter], then increments it. The edge clearing DEPTH-1 moves to READY. init_busy = 1 in INIT, 0 in READY.
- rst asserted mid-clear or mid-read restarts INIT from address 0 and drops all in-flight reads. No rvalid is produced for them.
- READY, write: on an edge with wen high, each byte with its wmask bit set takes the wdata byte. Other bytes keep their value. wmask all-zero means no change.
- READY, read: on an edge with ren high, word[raddr] is captured into pipeline stage 1. It advances one stage per edge. rdata/rvalid are driven from stage RD_LAT.
- Read data is fixed at the sampling edge. Writes on later edges never alter an in-flight read.
- Same edge, ren and wen, raddr == waddr: WRITE_FIRST=0 returns pre-write word. WRITE_FIRST=1 returns the byte-masked merge of the old word and wdata.
- ren/wen asserted while init_busy = 1 are ignored: no write, no rvalid.
- rdata holds its last valid value while rvalid = 0 (0 after reset).
- Back-to-back reads every cycle are sustained. There is no backpressure.

## Timing
- Reset values: init_busy 1, rvalid 0, rdata 0.
- Clear duration: with rst low from edge 1, edges 1..DEPTH clear words 0..DEPTH-1. init_busy is low after edge DEPTH. The first accepted access is sampled at edge DEPTH+1.
- Read issued at edge N: rvalid = 1 and rdata valid after edge N+RD_LAT-1 settles, i.e. visible to the consumer sampling at edge N+RD_LAT. RD_LAT=1 matches the legacy single-cycle BRAM.
- Write at edge N is visible to a read sampled at edge N+1 under either policy. At edge N it follows WRITE_FIRST.
- Throughput: 1 read and 1 write per cycle.

## Test plan
(DATA_W=64, ADDR_W=4, RD_LAT=2 unless stated.)
- Reset and clear: hold rst 3 cycles, release. Expect init_busy high for exactly 16 edges, then low. Reads of addresses 0..15 all return 0x0 with rvalid two edges after each ren.
- Masked write: write 0x1122334455667788 mask 0xFF to addr 5, then 0xAAAAAAAAAAAAAAAA mask 0x0F. Read addr 5, expecting 0x11223344AAAAAAAA.
- Collision: addr 3 holds 0x1. Same edge ren/wen to addr 3, wdata 0x2, mask 0xFF. WRITE_FIRST=0 returns 0x1; WRITE_FIRST=1 returns 0x2. A read on the next edge returns 0x2 in both cases.
- Streaming/latency: write addr k = k for k=0..15, then ren every cycle over 0..15. Expect 16 consecutive rvalid cycles starting 2 edges after the first ren, data 0..15 in order. Repeat with RD_LAT=1 and RD_LAT=4.
- Reset mid-read: issue a read of addr 7, assert rst one edge later. Expect no rvalid, rdata 0, a full 16-cycle clear, and addr 7 reads 0 afterwards.
- Access during clear: wen to addr 2 with 0xFF…FF and ren at edge 4 of INIT. Expect no rvalid, and addr 2 reads 0 after clear.
